ec_malf_monitor: RTL and testbench

Multi-channel sign-code malfunction monitor for the error-correcting arithmetic datapath. Each cycle it checks NUM_CH two-bit sign codes from the digit-recovery logic and raises a registered per-sample malfunction flag. It also keeps per-channel sticky flags and a saturating error counter. A consecutive-error state machine drives an acknowledged alarm. It sits beside the digit-recovery stage and feeds the TPU status/interrupt path.

---
 rtl/ec_malf_monitor.sv | 132 +++++++++++++
 tb/tb_ec_malf_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ec_malf_monitor.sv
// ec_malf_monitor: multi-channel sign-code malfunction monitor.
// Checks NUM_CH two-bit sign codes per cycle. It flags codes 1 and 3 as
// malfunctions, registers per-sample flags, keeps sticky per-channel history
// and a saturating error count. It also raises an alarm after RUN_LEN
// consecutive erroneous samples; the alarm holds until it is acknowledged.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   valid_in     sign_in carries a sample this cycle
//   sign_in      packed codes, channel i at [2i+1:2i]
//   clr          synchronous clear of malf_sticky and err_cnt
//   alarm_ack    acknowledge, clears alarm
//   Y            malfunction flag for the previous cycle's sample
//   malf_ch      per-channel malfunction flags for the previous sample
//   malf_sticky  per-channel sticky malfunction history
//   err_cnt      saturating count of malfunctioning samples
//   alarm        consecutive-malfunction alarm
module ec_malf_monitor #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RUN_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [2*NUM_CH-1:0]   sign_in,
  input  logic                  clr,
  input  logic                  alarm_ack,
  output logic                  Y,
  output logic [NUM_CH-1:0]     malf_ch,
  output logic [NUM_CH-1:0]     malf_sticky,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  alarm
);

  localparam int unsigned RUN_W = 8;
  localparam logic [RUN_W-1:0] RUN_LEN_C = RUN_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    MONITOR = 1'b0,
    ALARM   = 1'b1
  } state_t;

  state_t             state;
  logic [RUN_W-1:0]   run_cnt;
  logic [NUM_CH-1:0]  chan_err;
  logic               sample_err;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_next;
  logic [NUM_CH-1:0]  sticky_next;
  logic [1:0]         code;

  // Per-channel decode: only codes 0 and 2 are legal
  always_comb begin
    chan_err = '0;
    code     = 2'b00;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      code        = sign_in[2*i +: 2];
      chan_err[i] = valid_in & (code != 2'b00) & (code != 2'b10);
    end
  end

  assign sample_err = |chan_err;

  // Clear applies before the new error, so a colliding error survives
  always_comb begin
    cnt_base    = clr ? '0 : err_cnt;
    cnt_next    = cnt_base;
    if (sample_err && (cnt_base != CNT_MAX)) begin
      cnt_next = cnt_base + CNT_W'(1);
    end
    sticky_next = (clr ? '0 : malf_sticky) | chan_err;
  end

  // Per-sample flags, sticky history and error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y           <= 1'b0;
      malf_ch     <= '0;
      malf_sticky <= '0;
      err_cnt     <= '0;
    end else begin
      Y           <= sample_err;
      malf_ch     <= chan_err;
      malf_sticky <= sticky_next;
      err_cnt     <= cnt_next;
    end
  end

  // Consecutive-error tracker; invalid cycles leave the run untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MONITOR;
      run_cnt <= '0;
      alarm   <= 1'b0;
    end else begin
      case (state)
        MONITOR: begin
          if (valid_in) begin
            if (sample_err) begin
              if ((run_cnt + RUN_W'(1)) == RUN_LEN_C) begin
                state   <= ALARM;
                alarm   <= 1'b1;
                run_cnt <= '0;
              end else begin
                run_cnt <= run_cnt + RUN_W'(1);
              end
            end else begin
              run_cnt <= '0;
            end
          end
        end
        ALARM: begin
          // Samples during the alarm, including on the ack cycle, never start a run
          if (alarm_ack) begin
            state   <= MONITOR;
            alarm   <= 1'b0;
            run_cnt <= '0;
          end
        end
        default: begin
          state   <= MONITOR;
          alarm   <= 1'b0;
          run_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ec_malf_monitor.sv
// Testbench for ec_malf_monitor: table-driven vectors on a 4-channel
// instance plus hand-written sequences, and a 1-channel CNT_W=2,
// RUN_LEN=1 instance for saturation and the single-sample alarm.
module tb_ec_malf_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in, clr, alarm_ack;
  logic [7:0] sign_in;
  logic       y;
  logic [3:0] malf_ch, malf_sticky;
  logic [7:0] err_cnt;
  logic       alarm;

  logic       s_valid, s_clr, s_ack;
  logic [1:0] s_sign;
  logic       s_y;
  logic [0:0] s_ch, s_sticky;
  logic [1:0] s_cnt;
  logic       s_alarm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ec_malf_monitor #(.NUM_CH(4), .CNT_W(8), .RUN_LEN(3)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sign_in(sign_in),
    .clr(clr), .alarm_ack(alarm_ack), .Y(y), .malf_ch(malf_ch),
    .malf_sticky(malf_sticky), .err_cnt(err_cnt), .alarm(alarm)
  );

  ec_malf_monitor #(.NUM_CH(1), .CNT_W(2), .RUN_LEN(1)) dut_sat (
    .clk(clk), .rst(rst), .valid_in(s_valid), .sign_in(s_sign),
    .clr(s_clr), .alarm_ack(s_ack), .Y(s_y), .malf_ch(s_ch),
    .malf_sticky(s_sticky), .err_cnt(s_cnt), .alarm(s_alarm)
  );

  typedef struct {
    logic       v;
    logic [7:0] s;
    logic       c;
    logic       a;
    logic       exp_y;
    logic [3:0] exp_ch;
    logic [3:0] exp_st;
    logic [7:0] exp_cnt;
    logic       exp_al;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_main(input string tag, input logic ey, input logic [3:0] ech,
                          input logic [3:0] est, input logic [7:0] ecnt, input logic eal);
    chk({tag, ".Y"},           32'(y),           32'(ey));
    chk({tag, ".malf_ch"},     32'(malf_ch),     32'(ech));
    chk({tag, ".malf_sticky"}, 32'(malf_sticky), 32'(est));
    chk({tag, ".err_cnt"},     32'(err_cnt),     32'(ecnt));
    chk({tag, ".alarm"},       32'(alarm),       32'(eal));
  endtask

  // Drive one sample into the main instance and step past the edge
  task automatic drive(input logic v, input logic [7:0] s, input logic c, input logic a);
    valid_in  = v;
    sign_in   = s;
    clr       = c;
    alarm_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic sdrive(input logic v, input logic [1:0] s, input logic a);
    s_valid = v;
    s_sign  = s;
    s_ack   = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0; sign_in = 8'h00; clr = 1'b0; alarm_ack = 1'b0;
    s_valid = 1'b0; s_sign = 2'b00; s_clr = 1'b0; s_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_main("reset", 1'b0, 4'h0, 4'h0, 8'd0, 1'b0);
    rst = 1'b0;

    //              v  sign  clr ack  Y  ch    st    cnt    al
    // Code decode
    vecs.push_back('{1, 8'h88, 0, 0, 0, 4'h0, 4'h0, 8'd0,  0});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'h1, 8'd1,  0});
    vecs.push_back('{1, 8'hC0, 0, 0, 1, 4'h8, 4'h9, 8'd2,  0});
    vecs.push_back('{1, 8'h88, 0, 0, 0, 4'h0, 4'h9, 8'd2,  0});
    // err, err, ok, err, gap, err, err -> alarm on the last edge only
    vecs.push_back('{1, 8'h04, 0, 0, 1, 4'h2, 4'hB, 8'd3,  0});
    vecs.push_back('{1, 8'h10, 0, 0, 1, 4'h4, 4'hF, 8'd4,  0});
    vecs.push_back('{1, 8'h22, 0, 0, 0, 4'h0, 4'hF, 8'd4,  0});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd5,  0});
    vecs.push_back('{0, 8'hFF, 0, 0, 0, 4'h0, 4'hF, 8'd5,  0});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd6,  0});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd7,  1});
    // Errors during ALARM count but alarm holds
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd8,  1});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd9,  1});
    // Ack, then three fresh errors needed
    vecs.push_back('{0, 8'h00, 0, 1, 0, 4'h0, 4'hF, 8'd9,  0});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd10, 0});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd11, 0});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd12, 1});
    // Ack together with an error: error counted, not part of a new run
    vecs.push_back('{1, 8'h01, 0, 1, 1, 4'h1, 4'hF, 8'd13, 0});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd14, 0});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd15, 0});
    vecs.push_back('{1, 8'h01, 0, 0, 1, 4'h1, 4'hF, 8'd16, 1});
    vecs.push_back('{0, 8'h00, 0, 1, 0, 4'h0, 4'hF, 8'd16, 0});
    // Ack held in MONITOR has no effect; clr alone empties history
    vecs.push_back('{0, 8'h00, 0, 1, 0, 4'h0, 4'hF, 8'd16, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 4'h0, 4'h0, 8'd0,  0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].c, vecs[i].a);
      chk_main($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_ch,
               vecs[i].exp_st, vecs[i].exp_cnt, vecs[i].exp_al);
    end

    // clr collision: build sticky=0101, err_cnt=7 without alarming
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'h11, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 1'b0, 1'b0);
    end
    chk_main("clr_pre", 1'b0, 4'h0, 4'h5, 8'd7, 1'b0);
    drive(1'b1, 8'h04, 1'b1, 1'b0);
    chk_main("clr_coll", 1'b1, 4'h2, 4'h2, 8'd1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk_main("clr_only", 1'b0, 4'h0, 4'h0, 8'd0, 1'b0);

    // Async reset mid-operation with err_cnt=5 and alarm=1
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h40, 1'b0, 1'b0);
    chk_main("pre_rst", 1'b1, 4'h8, 4'h8, 8'd5, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_main("async_rst", 1'b0, 4'h0, 4'h0, 8'd0, 1'b0);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'hFF, 1'b0, 1'b0);
      chk_main($sformatf("idle%0d", i), 1'b0, 4'h0, 4'h0, 8'd0, 1'b0);
    end
    // Partial run discarded by reset: two errors after reset must not alarm
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    chk_main("post_rst_run", 1'b1, 4'h1, 4'h1, 8'd2, 1'b0);

    // Saturation with CNT_W=2, RUN_LEN=1
    sdrive(1'b1, 2'b10, 1'b0);
    chk("sat_ok.Y", 32'(s_y), 32'd0);
    chk("sat_ok.alarm", 32'(s_alarm), 32'd0);
    for (int i = 0; i < 5; i++) begin
      sdrive(1'b1, 2'b11, 1'b0);
      chk($sformatf("sat%0d.err_cnt", i), 32'(s_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("sat%0d.Y", i), 32'(s_y), 32'd1);
      chk($sformatf("sat%0d.alarm", i), 32'(s_alarm), 32'd1);
    end
    chk("sat.sticky", 32'(s_sticky), 32'd1);
    chk("sat.ch", 32'(s_ch), 32'd1);
    sdrive(1'b0, 2'b00, 1'b1);
    chk("sat_ack.alarm", 32'(s_alarm), 32'd0);
    sdrive(1'b1, 2'b01, 1'b0);
    chk("sat_realarm.alarm", 32'(s_alarm), 32'd1);
    chk("sat_realarm.err_cnt", 32'(s_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
